// File: rtl/pip_pkg.sv
// Shared definitions for the pipeline hazard/forwarding controller:
// operand-select encodings, hazard state encoding and default address width.
package pip_pkg;

   localparam int REG_AW = 5;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_LD_STALL = 2'd1,
      ST_MEM_WAIT = 2'd2
   } hz_state_t;

endpackage

// File: rtl/pip_fwd_sel.sv
// Single-operand forward selector: picks EX/MEM, MEM/WB or the register file
// for one EX-stage source operand. The younger EX/MEM result wins.
module pip_fwd_sel
   import pip_pkg::*;
#(
   parameter int AW = REG_AW
) (
   input  logic          i_rs_read,
   input  logic [AW-1:0] i_rs_ad,
   input  logic          i_mem_rdEn,
   input  logic [AW-1:0] i_mem_rd,
   input  logic          i_wb_rdEn,
   input  logic [AW-1:0] i_wb_rd,
   output logic [1:0]    o_fwd
);

   logic w_mem_hit;
   logic w_wb_hit;

   // x0 is hard-wired zero, so a write to it never produces a forward.
   assign w_mem_hit = i_rs_read & i_mem_rdEn & (i_mem_rd != '0) & (i_mem_rd == i_rs_ad);
   assign w_wb_hit  = i_rs_read & i_wb_rdEn  & (i_wb_rd  != '0) & (i_wb_rd  == i_rs_ad);

   always_comb begin
      o_fwd = FWD_REG;
      if (w_mem_hit) begin
         o_fwd = FWD_MEM;
      end else if (w_wb_hit) begin
         o_fwd = FWD_WB;
      end
   end

endmodule

// File: rtl/pip_hazard_ctrl.sv
// Hazard and forwarding controller: load-use stalls, taken-branch squash,
// data-memory wait freezes and EX-stage operand forwarding selects.
//
// state       | meaning
// ST_RUN      | normal flow, no hazard pending
// ST_LD_STALL | one-cycle load-use bubble is in EX
// ST_MEM_WAIT | MEM access outstanding, whole pipeline frozen
module pip_hazard_ctrl #(
   parameter int REG_AW = pip_pkg::REG_AW,
   parameter int CNT_W  = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_id_valid,
   input  logic [REG_AW-1:0] i_id_rs1_ad,
   input  logic [REG_AW-1:0] i_id_rs2_ad,
   input  logic              i_id_rs1_read,
   input  logic              i_id_rs2_read,
   input  logic [REG_AW-1:0] i_ex_rs1_ad_p,
   input  logic [REG_AW-1:0] i_ex_rs2_ad_p,
   input  logic [REG_AW-1:0] i_ex_rd_ad_p,
   input  logic              i_ex_rs1_read_p,
   input  logic              i_ex_rs2_read_p,
   input  logic              i_ex_rdEn_p,
   input  logic              i_ex_DMread_p,
   input  logic              i_mem_dm_access,
   input  logic              i_dm_ready,
   input  logic              i_branch_taken,
   output logic              o_pc_en,
   output logic              o_ifid_en,
   output logic              o_ifid_flush,
   output logic              o_idex_en,
   output logic              o_idex_bubble,
   output logic              o_exmem_en,
   output logic [1:0]        o_fwd_a,
   output logic [1:0]        o_fwd_b,
   output logic [CNT_W-1:0]  o_stall_cnt,
   output logic [CNT_W-1:0]  o_flush_cnt
);

   import pip_pkg::*;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   hz_state_t         r_state;
   hz_state_t         w_next;
   logic [REG_AW-1:0] r_mem_rd;
   logic [REG_AW-1:0] r_wb_rd;
   logic              r_mem_rdEn;
   logic              r_wb_rdEn;
   logic [CNT_W-1:0]  r_stall_cnt;
   logic [CNT_W-1:0]  r_flush_cnt;

   logic w_lu;
   logic w_freeze;
   logic w_pc_en;
   logic w_ifid_en;
   logic w_ifid_flush;
   logic w_idex_en;
   logic w_idex_bubble;
   logic w_exmem_en;
   logic w_stall_inc;
   logic w_flush_inc;

   assign w_lu = i_ex_DMread_p & i_ex_rdEn_p & (i_ex_rd_ad_p != '0) & i_id_valid &
                 ((i_id_rs1_read & (i_id_rs1_ad == i_ex_rd_ad_p)) |
                  (i_id_rs2_read & (i_id_rs2_ad == i_ex_rd_ad_p)));

   // Once frozen, only dm_ready releases the pipeline.
   assign w_freeze = (r_state == ST_MEM_WAIT) ? !i_dm_ready
                                              : (i_mem_dm_access & !i_dm_ready);

   always_comb begin
      w_pc_en       = 1'b1;
      w_ifid_en     = 1'b1;
      w_ifid_flush  = 1'b0;
      w_idex_en     = 1'b1;
      w_idex_bubble = 1'b0;
      w_exmem_en    = 1'b1;
      w_stall_inc   = 1'b0;
      w_flush_inc   = 1'b0;
      w_next        = ST_RUN;
      if (!i_rst) begin
         if (w_freeze) begin
            w_pc_en    = 1'b0;
            w_ifid_en  = 1'b0;
            w_idex_en  = 1'b0;
            w_exmem_en = 1'b0;
            w_next     = ST_MEM_WAIT;
         end else if (i_branch_taken) begin
            // The dependent decode instruction is squashed, so a load-use is moot.
            w_ifid_flush  = 1'b1;
            w_idex_bubble = 1'b1;
            w_flush_inc   = 1'b1;
         end else if (w_lu) begin
            w_pc_en       = 1'b0;
            w_ifid_en     = 1'b0;
            w_idex_bubble = 1'b1;
            w_stall_inc   = 1'b1;
            w_next        = ST_LD_STALL;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_mem_rd   <= '0;
         r_mem_rdEn <= 1'b0;
         r_wb_rd    <= '0;
         r_wb_rdEn  <= 1'b0;
      end else if (w_exmem_en) begin
         r_mem_rd   <= i_ex_rd_ad_p;
         r_mem_rdEn <= i_ex_rdEn_p;
         r_wb_rd    <= r_mem_rd;
         r_wb_rdEn  <= r_mem_rdEn;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_stall_inc && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
         end
         if (w_flush_inc && (r_flush_cnt != '1)) begin
            r_flush_cnt <= r_flush_cnt + CNT_ONE;
         end
      end
   end

   pip_fwd_sel #(.AW(REG_AW)) u_fwd_a (
      .i_rs_read  (i_ex_rs1_read_p),
      .i_rs_ad    (i_ex_rs1_ad_p),
      .i_mem_rdEn (r_mem_rdEn),
      .i_mem_rd   (r_mem_rd),
      .i_wb_rdEn  (r_wb_rdEn),
      .i_wb_rd    (r_wb_rd),
      .o_fwd      (o_fwd_a)
   );

   pip_fwd_sel #(.AW(REG_AW)) u_fwd_b (
      .i_rs_read  (i_ex_rs2_read_p),
      .i_rs_ad    (i_ex_rs2_ad_p),
      .i_mem_rdEn (r_mem_rdEn),
      .i_mem_rd   (r_mem_rd),
      .i_wb_rdEn  (r_wb_rdEn),
      .i_wb_rd    (r_wb_rd),
      .o_fwd      (o_fwd_b)
   );

   assign o_pc_en       = w_pc_en;
   assign o_ifid_en     = w_ifid_en;
   assign o_ifid_flush  = w_ifid_flush;
   assign o_idex_en     = w_idex_en;
   assign o_idex_bubble = w_idex_bubble;
   assign o_exmem_en    = w_exmem_en;
   assign o_stall_cnt   = r_stall_cnt;
   assign o_flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_pip_hazard_ctrl.sv
// Directed bench for pip_hazard_ctrl with a pipeline-history reference model
// checked every cycle, plus hand-computed spot checks.
module tb_pip_hazard_ctrl;

   localparam int AW = 5;
   localparam int CW = 16;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk;
   logic          rst;
   logic          id_valid;
   logic [AW-1:0] id_rs1_ad, id_rs2_ad;
   logic          id_rs1_read, id_rs2_read;
   logic [AW-1:0] ex_rs1_ad_p, ex_rs2_ad_p, ex_rd_ad_p;
   logic          ex_rs1_read_p, ex_rs2_read_p, ex_rdEn_p, ex_DMread_p;
   logic          mem_dm_access, dm_ready, branch_taken;
   logic          pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en;
   logic [1:0]    fwd_a, fwd_b;
   logic [CW-1:0] stall_cnt, flush_cnt;

   int n_chk = 0;
   int n_err = 0;

   pip_hazard_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_id_valid      (id_valid),
      .i_id_rs1_ad     (id_rs1_ad),
      .i_id_rs2_ad     (id_rs2_ad),
      .i_id_rs1_read   (id_rs1_read),
      .i_id_rs2_read   (id_rs2_read),
      .i_ex_rs1_ad_p   (ex_rs1_ad_p),
      .i_ex_rs2_ad_p   (ex_rs2_ad_p),
      .i_ex_rd_ad_p    (ex_rd_ad_p),
      .i_ex_rs1_read_p (ex_rs1_read_p),
      .i_ex_rs2_read_p (ex_rs2_read_p),
      .i_ex_rdEn_p     (ex_rdEn_p),
      .i_ex_DMread_p   (ex_DMread_p),
      .i_mem_dm_access (mem_dm_access),
      .i_dm_ready      (dm_ready),
      .i_branch_taken  (branch_taken),
      .o_pc_en         (pc_en),
      .o_ifid_en       (ifid_en),
      .o_ifid_flush    (ifid_flush),
      .o_idex_en       (idex_en),
      .o_idex_bubble   (idex_bubble),
      .o_exmem_en      (exmem_en),
      .o_fwd_a         (fwd_a),
      .o_fwd_b         (fwd_b),
      .o_stall_cnt     (stall_cnt),
      .o_flush_cnt     (flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   // Reference model: history of destinations that have left EX, youngest first.
   typedef struct {
      logic [AW-1:0] rd;
      logic          wen;
   } dst_t;

   dst_t hist[$];
   bit   m_wait;
   int   m_stall;
   int   m_flush;

   function automatic logic [1:0] model_fwd(input logic rd_use, input logic [AW-1:0] rs);
      if (!rd_use || rs == 0) return 2'b00;
      for (int i = 0; i < 2; i++) begin
         if (hist[i].wen && hist[i].rd == rs) return (i == 0) ? 2'b10 : 2'b01;
      end
      return 2'b00;
   endfunction

   always @(negedge clk) begin
      bit   waiting, lu, br, e_pc, e_ifid, e_flush, e_idex, e_bub, e_exm;
      logic [1:0] e_fa, e_fb;
      if (rst) begin
         hist.delete();
         hist.push_back('{rd: '0, wen: 1'b0});
         hist.push_back('{rd: '0, wen: 1'b0});
         m_wait  = 0;
         m_stall = 0;
         m_flush = 0;
         e_pc = 1; e_ifid = 1; e_flush = 0; e_idex = 1; e_bub = 0; e_exm = 1;
         e_fa = 2'b00; e_fb = 2'b00;
         waiting = 0; lu = 0; br = 0;
      end else begin
         waiting = (m_wait || mem_dm_access) && !dm_ready;
         lu = ex_DMread_p && ex_rdEn_p && ex_rd_ad_p != 0 && id_valid &&
              ((id_rs1_read && id_rs1_ad == ex_rd_ad_p) || (id_rs2_read && id_rs2_ad == ex_rd_ad_p));
         br = branch_taken;
         e_fa = model_fwd(ex_rs1_read_p, ex_rs1_ad_p);
         e_fb = model_fwd(ex_rs2_read_p, ex_rs2_ad_p);
         e_flush = 0; e_bub = 0;
         if (waiting) begin
            e_pc = 0; e_ifid = 0; e_idex = 0; e_exm = 0;
         end else begin
            e_idex = 1; e_exm = 1;
            e_pc   = br || !lu;
            e_ifid = br || !lu;
            e_flush = br;
            e_bub  = br || lu;
         end
      end
      chk("m_pc_en", pc_en, e_pc);
      chk("m_ifid_en", ifid_en, e_ifid);
      chk("m_ifid_flush", ifid_flush, e_flush);
      chk("m_idex_en", idex_en, e_idex);
      chk("m_idex_bubble", idex_bubble, e_bub);
      chk("m_exmem_en", exmem_en, e_exm);
      chk("m_fwd_a", fwd_a, e_fa);
      chk("m_fwd_b", fwd_b, e_fb);
      chk("m_stall_cnt", stall_cnt, m_stall);
      chk("m_flush_cnt", flush_cnt, m_flush);
      if (!rst) begin
         if (!waiting) begin
            hist.push_front('{rd: ex_rd_ad_p, wen: ex_rdEn_p});
            void'(hist.pop_back());
            if (br) m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
            else if (lu) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
         end
         m_wait = waiting;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      id_valid = 0; id_rs1_ad = '0; id_rs2_ad = '0; id_rs1_read = 0; id_rs2_read = 0;
      ex_rs1_ad_p = '0; ex_rs2_ad_p = '0; ex_rd_ad_p = '0;
      ex_rs1_read_p = 0; ex_rs2_read_p = 0; ex_rdEn_p = 0; ex_DMread_p = 0;
      mem_dm_access = 0; dm_ready = 1; branch_taken = 0;
   endtask

   task automatic set_load_use(input logic [AW-1:0] r);
      ex_rd_ad_p = r; ex_rdEn_p = 1; ex_DMread_p = 1;
      id_valid = 1; id_rs1_read = 1; id_rs1_ad = r;
   endtask

   initial begin
      clr();
      rst = 1;
      mem_dm_access = 1; dm_ready = 0;
      #12;
      chk("rst_pc_en", pc_en, 1);
      chk("rst_exmem_en", exmem_en, 1);
      chk("rst_stall_cnt", stall_cnt, 0);
      @(posedge clk); #1;
      rst = 0;
      clr();
      cyc();

      // load-use stall then forwarding from MEM/WB
      set_load_use(5'd5);
      #1;
      chk("lu_pc_en", pc_en, 0);
      chk("lu_ifid_en", ifid_en, 0);
      chk("lu_idex_en", idex_en, 1);
      chk("lu_bubble", idex_bubble, 1);
      cyc();
      ex_rd_ad_p = '0; ex_rdEn_p = 0; ex_DMread_p = 0;
      #1;
      chk("lu_stall_cnt", stall_cnt, 1);
      chk("lds_pc_en", pc_en, 1);
      chk("lds_bubble", idex_bubble, 0);
      cyc();
      clr();
      ex_rs1_read_p = 1; ex_rs1_ad_p = 5'd5; ex_rd_ad_p = 5'd6; ex_rdEn_p = 1;
      #1;
      chk("lu_fwd_a_wb", fwd_a, 2'b01);
      cyc();

      // ALU producer followed by consumers
      clr();
      ex_rd_ad_p = 5'd7; ex_rdEn_p = 1;
      cyc();
      ex_rd_ad_p = 5'd8; ex_rs2_read_p = 1; ex_rs2_ad_p = 5'd7;
      #1;
      chk("alu_fwd_b_mem", fwd_b, 2'b10);
      cyc();
      ex_rd_ad_p = '0; ex_rdEn_p = 0;
      #1;
      chk("alu_fwd_b_wb", fwd_b, 2'b01);
      cyc();
      clr();
      ex_rd_ad_p = '0; ex_rdEn_p = 1;
      cyc();
      ex_rdEn_p = 0; ex_rs2_read_p = 1; ex_rs2_ad_p = '0;
      #1;
      chk("x0_fwd_b", fwd_b, 2'b00);
      cyc();

      // x3 pending in both shadows: EX/MEM wins
      clr();
      ex_rd_ad_p = 5'd3; ex_rdEn_p = 1;
      cyc();
      cyc();
      ex_rd_ad_p = '0; ex_rdEn_p = 0; ex_rs1_read_p = 1; ex_rs1_ad_p = 5'd3;
      #1;
      chk("prio_fwd_a", fwd_a, 2'b10);
      cyc();

      // load-use and taken branch together
      clr();
      ex_rd_ad_p = 5'd5; ex_rdEn_p = 1; ex_DMread_p = 1;
      id_valid = 1; id_rs2_read = 1; id_rs2_ad = 5'd5;
      branch_taken = 1;
      #1;
      chk("br_flush", ifid_flush, 1);
      chk("br_bubble", idex_bubble, 1);
      chk("br_pc_en", pc_en, 1);
      chk("br_ifid_en", ifid_en, 1);
      cyc();
      clr();
      #1;
      chk("br_stall_cnt", stall_cnt, 1);
      chk("br_flush_cnt", flush_cnt, 1);

      // data-memory wait: three frozen cycles then release
      cyc();
      cyc();
      mem_dm_access = 1; dm_ready = 0;
      ex_rd_ad_p = 5'd11; ex_rdEn_p = 1; ex_rs1_read_p = 1; ex_rs1_ad_p = 5'd11;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("mw_pc_en", pc_en, 0);
         chk("mw_exmem_en", exmem_en, 0);
         chk("mw_ifid_en", ifid_en, 0);
         chk("mw_fwd_a_held", fwd_a, 2'b00);
         cyc();
      end
      dm_ready = 1;
      #1;
      chk("rel_pc_en", pc_en, 1);
      chk("rel_exmem_en", exmem_en, 1);
      chk("rel_stall_cnt", stall_cnt, 1);
      chk("rel_flush_cnt", flush_cnt, 1);
      cyc();
      mem_dm_access = 0;
      #1;
      chk("rel_fwd_a_mem", fwd_a, 2'b10);
      cyc();

      // reset in the middle of MEM_WAIT
      clr();
      mem_dm_access = 1; dm_ready = 0;
      cyc();
      cyc();
      #2;
      rst = 1;
      #1;
      chk("rmw_pc_en", pc_en, 1);
      chk("rmw_exmem_en", exmem_en, 1);
      chk("rmw_flush_cnt", flush_cnt, 0);
      chk("rmw_stall_cnt", stall_cnt, 0);
      cyc();
      rst = 0; mem_dm_access = 0; dm_ready = 0;
      #1;
      chk("rmw_run_pc_en", pc_en, 1);
      cyc();

      // reset in the middle of LD_STALL
      clr();
      set_load_use(5'd9);
      cyc();
      #2;
      rst = 1;
      #1;
      chk("rls_pc_en", pc_en, 1);
      chk("rls_bubble", idex_bubble, 0);
      chk("rls_fwd_a", fwd_a, 2'b00);
      chk("rls_stall_cnt", stall_cnt, 0);
      cyc();
      rst = 0;
      clr();
      cyc();

      // saturation of the stall counter under a continuous load chain
      set_load_use(5'd5);
      repeat (CMAX - 5) cyc();
      chk("sat_near", stall_cnt, CMAX - 5);
      repeat (10) cyc();
      chk("sat_full", stall_cnt, CMAX);
      clr();
      cyc();
      cyc();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
